// File: rtl/psum_collector.sv
// Partial-sum scratchpad with done-value output FIFO and pipeline back-pressure.
// Optional ReLU on the FIFO path: define PSUM_COLLECT_RELU_EN.
module psum_collector #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [WIDTH-1:0]  Psum,
    input  logic              wen_Psum,
    input  logic              done_psum,
    output logic [WIDTH-1:0]  Psum_in,
    output logic              stall,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              pass_done
);

    localparam int OPTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]    spad_q [DEPTH];
    logic [WIDTH-1:0]    fifo_q [OUT_DEPTH];
    logic [OPTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                wr_acc;
    logic                push;
    logic                pop;
    logic [WIDTH-1:0]    push_data;

`ifdef PSUM_COLLECT_RELU_EN
    assign push_data = Psum[WIDTH-1] ? '0 : Psum;
`else
    assign push_data = Psum;
`endif

    // Stall comes only from the registered count so it never depends on this cycle's pop.
    assign stall     = (cnt_q == CNT_W'(OUT_DEPTH));
    assign wr_acc    = (state_q == ACCUM) && wen_Psum && !stall;
    assign push      = wr_acc && done_psum;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_q[rd_q] : '0;
    assign Psum_in   = spad_q[ptr_q];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        pass_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    ptr_d   = '0;
                    len_d   = len;
                end
            end
            ACCUM: begin
                if (wr_acc) begin
                    ptr_d = (ptr_q == len_q) ? '0 : ptr_q + ADDR_W'(1);
                    if (done_psum && (ptr_q == len_q)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !push) begin
                    state_d   = IDLE;
                    pass_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            for (int i = 0; i < DEPTH; i++) spad_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            if (wr_acc) spad_q[ptr_q] <= Psum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                fifo_q[wr_q] <= push_data;
                wr_q         <= wr_q + OPTR_W'(1);
            end
            if (pop) rd_q <= rd_q + OPTR_W'(1);
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: pass flow, back-pressure, push/pop, reset, ReLU, wrap.
module tb_psum_collector;

    logic        clk, rst, start;
    logic [2:0]  len;
    logic [15:0] Psum;
    logic        wen_Psum, done_psum, out_ready;
    logic [15:0] Psum_in, out_data;
    logic        stall, out_valid, busy, pass_done;

    int checks = 0;
    int errors = 0;

    psum_collector #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .Psum(Psum),
        .wen_Psum(wen_Psum), .done_psum(done_psum), .Psum_in(Psum_in),
        .stall(stall), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .pass_done(pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; len = '0; Psum = '0;
        wen_Psum = 1'b0; done_psum = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic begin_pass(input logic [2:0] l);
        start = 1'b1; len = l;
        step();
        start = 1'b0;
    endtask

    task automatic wr(input logic [15:0] v, input logic d);
        Psum = v; wen_Psum = 1'b1; done_psum = d;
        step();
        wen_Psum = 1'b0; done_psum = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; len = '0; Psum = '0;
        wen_Psum = 1'b0; done_psum = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if ({Psum_in, out_data, stall, out_valid, busy, pass_done} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: Psum_in=%h out_data=%h stall=%b vld=%b busy=%b pd=%b want all 0",
                     Psum_in, out_data, stall, out_valid, busy, pass_done);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_pass();
        logic [15:0] exp_in [3];
        logic [15:0] exp_out [3];
        int pd_cnt;
        exp_in  = '{16'd7, 16'd9, 16'd10};
        exp_out = '{16'd10, 16'd20, 16'd30};
        do_reset();
        begin_pass(3'd2);
        wr(16'd5, 1'b0); wr(16'd7, 1'b0); wr(16'd9, 1'b0);
        checks++;
        if (Psum_in !== 16'd5) begin
            errors++; $display("FAIL basic_lap2_entry0: got %0d want 5", Psum_in);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr(exp_out[i], 1'b1);
            checks++;
            if (Psum_in !== exp_in[i]) begin
                errors++; $display("FAIL basic_psum_in[%0d]: got %0d want %0d", i, Psum_in, exp_in[i]);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin
                errors++; $display("FAIL basic_out[%0d]: got vld=%b data=%0d want 1/%0d",
                                   i, out_valid, out_data, exp_out[i]);
            end
        end
        pd_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (pass_done) pd_cnt++;
        end
        checks++;
        if (pd_cnt != 1) begin
            errors++; $display("FAIL basic_pass_done_pulses: got %0d want 1", pd_cnt);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle: busy=%b vld=%b want 0/0", busy, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [15:0] got [8];
        int idx, npop, stall_cyc;
        logic acc, pp;
        do_reset();
        begin_pass(3'd7);
        out_ready = 1'b0;
        idx = 1; npop = 0; stall_cyc = 0;
        for (int c = 0; c < 60 && npop < 8; c++) begin
            if (idx <= 8) begin
                wen_Psum = 1'b1; done_psum = 1'b1; Psum = 16'(idx);
            end else begin
                wen_Psum = 1'b0; done_psum = 1'b0;
            end
            acc = wen_Psum && !stall;
            pp  = out_valid && out_ready;
            if (pp) begin got[npop] = out_data; npop++; end
            step();
            if (acc) begin
                idx++;
                if (idx == 5) begin
                    checks++;
                    if (stall !== 1'b1) begin
                        errors++; $display("FAIL bp_stall_after_4: got %b want 1", stall);
                    end
                end
            end
            if (stall && !out_ready) begin
                stall_cyc++;
                checks++;
                if (Psum_in !== 16'd0 || out_data !== 16'd1) begin
                    errors++; $display("FAIL bp_held: Psum_in=%0d out_data=%0d want 0/1", Psum_in, out_data);
                end
                if (stall_cyc == 3) out_ready = 1'b1;
            end
        end
        wen_Psum = 1'b0; done_psum = 1'b0;
        checks++;
        if (npop != 8 || stall_cyc != 3) begin
            errors++; $display("FAIL bp_counts: pops=%0d stall_cycles=%0d want 8/3", npop, stall_cyc);
        end
        for (int k = 0; k < npop; k++) begin
            checks++;
            if (got[k] !== 16'(k + 1)) begin
                errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, got[k], k + 1);
            end
        end
        for (int c = 0; c < 10 && busy; c++) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_busy_fall: got %b want 0", busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop_at_3();
        do_reset();
        begin_pass(3'd7);
        out_ready = 1'b0;
        wr(16'd1, 1'b1); wr(16'd2, 1'b1); wr(16'd3, 1'b1);
        out_ready = 1'b1;
        wr(16'd4, 1'b1);
        out_ready = 1'b0;
        checks++;
        if (stall !== 1'b0 || out_data !== 16'd2) begin
            errors++; $display("FAIL pp_count3: stall=%b head=%0d want 0/2", stall, out_data);
        end
        wr(16'd5, 1'b1);
        checks++;
        if (stall !== 1'b1 || out_data !== 16'd2) begin
            errors++; $display("FAIL pp_fill_to_4: stall=%b head=%0d want 1/2", stall, out_data);
        end
    endtask

    task automatic test_reset_mid_accum();
        do_reset();
        begin_pass(3'd3);
        wr(16'd11, 1'b1); wr(16'd22, 1'b1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({Psum_in, out_data, stall, out_valid, busy, pass_done} !== 36'h0) begin
            errors++;
            $display("FAIL midrst_outputs: Psum_in=%h out_data=%h stall=%b vld=%b busy=%b pd=%b want all 0",
                     Psum_in, out_data, stall, out_valid, busy, pass_done);
        end
        step();
        rst = 1'b1;
        step();
        wr(16'd99, 1'b1);
        checks++;
        if (Psum_in !== 16'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle_write: Psum_in=%0d busy=%b vld=%b want 0/0/0",
                               Psum_in, busy, out_valid);
        end
    endtask

    task automatic test_relu();
        logic [15:0] exp_out;
`ifdef PSUM_COLLECT_RELU_EN
        exp_out = 16'h0000;
`else
        exp_out = 16'hFFFD;
`endif
        do_reset();
        begin_pass(3'd0);
        out_ready = 1'b0;
        wr(16'hFFFD, 1'b1);
        checks++;
        if (Psum_in !== 16'hFFFD || out_valid !== 1'b1 || out_data !== exp_out) begin
            errors++; $display("FAIL relu: Psum_in=%h vld=%b out_data=%h want FFFD/1/%h",
                               Psum_in, out_valid, out_data, exp_out);
        end
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_len0();
        logic [15:0] v;
        do_reset();
        begin_pass(3'd0);
        for (int i = 1; i <= 3; i++) begin
            v = 16'(i);
            wr(v, 1'b0);
            checks++;
            if (Psum_in !== v || busy !== 1'b1) begin
                errors++; $display("FAIL wrap_len0[%0d]: Psum_in=%0d busy=%b want %0d/1", i, Psum_in, busy, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_back_pressure();
        test_push_pop_at_3();
        test_reset_mid_accum();
        test_relu();
        test_wrap_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
